vpi_access_arbiter: RTL and testbench
=====================================

# vpi_access_arbiter

Round-robin arbiter and sequencer that shares a single backdoor value-access port between NUM_REQ requesters. Requesters are bench agents or RTL bridges issuing get/put-value operations on object handles. The block serialises requests, drives one outstanding access at a time, enforces a response timeout, and routes the result back to the originating requester. It sits between the handle/value access layer and the single simulator-side access channel.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- HANDLE_W, 16, object handle width
- DATA_W, 32, value width
- TIMEOUT, 255, max cycles from issue to response (1..65535)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low
- req_valid  in  NUM_REQ  per-requester request valid, held until req_ready
- req_ready  out  NUM_REQ  one-hot pulse; request accepted this cycle
- req_put  in  NUM_REQ  per-requester op: 1 = put value, 0 = get value
- req_handle  in  NUM_REQ*HANDLE_W  packed handles, requester i at [i*HANDLE_W +: HANDLE_W]
- req_value  in  NUM_REQ*DATA_W  packed put values
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_value  out  DATA_W  get result; 0 for put or on error
- rsp_status  out  2  0 = ok, 1 = access error, 2 = timeout
- acc_valid  out  1  access request to backdoor channel
- acc_ready  in  1  channel accepts access
- acc_put, acc_handle, acc_value  out  1/HANDLE_W/DATA_W  latched op fields
- acc_rsp_valid  in  1  channel response strobe
- acc_rsp_value  in  DATA_W  channel get result
- acc_rsp_error  in  1  channel reports bad handle/op
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant the first set bit at or after rr_ptr (wrapping), pulse req_ready[grant], latch op/handle/value/grant, clear timer, go to ISSUE. rr_ptr <= grant+1 mod NUM_REQ.
- ISSUE: acc_valid=1 with latched fields. On acc_ready go to WAIT.
- WAIT: on acc_rsp_valid latch value/status (error -> status 1, value 0; put -> value 0), go to RESP.
- Timer increments every ISSUE/WAIT cycle. When it reaches TIMEOUT without acc_rsp_valid: status 2, value 0, drop acc_valid, go to RESP.
- If acc_rsp_valid and timer expiry coincide, the response wins (status 0/1).
- RESP: rsp_valid[grant]=1 for one cycle with latched rsp_value/rsp_status, then go to IDLE.
- acc_rsp_valid outside WAIT is ignored, including late responses after a timeout.
- Requesters not granted keep req_valid high. The block never drops or reorders a request.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_value 0, rsp_status 0, acc_valid 0, acc_put 0, acc_handle 0, acc_value 0, busy 0, timer 0.
- Reset mid-operation abandons the access. No rsp_valid is generated, and acc_valid drops on the first reset cycle.
- Minimum latency, with acc_ready already high and the response in the first WAIT cycle:
  - req_ready at cycle 0
  - acc_valid at cycle 1
  - WAIT at cycle 2, acc_rsp_valid sampled
  - rsp_valid at cycle 3
- Back-to-back throughput: one access per 4 cycles minimum. Next grant is possible in the IDLE cycle after RESP.
- acc_valid stays high and acc fields stay stable until acc_ready, per the valid/ready rule.
- Timeout: rsp_valid asserts TIMEOUT+1 cycles after acc_valid first rises if no response arrives.

## Test plan
- Single get: requester 2 handle 0x0042; channel returns 0xDEADBEEF one cycle after acc_ready -> rsp_valid=4'b0100, rsp_value=0xDEADBEEF, status 0, 3-cycle latency from req_ready.
- Fairness: all 4 requesters held valid, 8 accesses -> grant order 0,1,2,3,0,1,2,3; each req_ready strictly one-hot.
- Put with error: requester 1 put 0x5A5A to handle 0xFFFF; channel asserts acc_rsp_error -> rsp_valid[1], status 1, rsp_value 0.
- Timeout: TIMEOUT=8, channel never responds -> status 2 on rsp_valid 9 cycles after acc_valid rose; a late acc_rsp_valid is ignored and the next request proceeds normally.
- Backpressure and coincidence: acc_ready low for 5 cycles -> acc fields stable throughout. acc_rsp_valid on the expiry cycle -> status 0.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle -> all outputs return to reset values, no rsp_valid, rr_ptr=0 so requester 0 wins next.

Source files
------------

// File: rtl/vpi_access_arbiter.sv
// rtl/vpi_access_arbiter.sv - round-robin sequencer sharing one backdoor value-access channel
module vpi_access_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HANDLE_W = 16,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_put,
  input  logic [NUM_REQ*HANDLE_W-1:0]  req_handle,
  input  logic [NUM_REQ*DATA_W-1:0]    req_value,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_value,
  output logic [1:0]                   rsp_status,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic                         acc_put,
  output logic [HANDLE_W-1:0]          acc_handle,
  output logic [DATA_W-1:0]            acc_value,
  input  logic                         acc_rsp_valid,
  input  logic [DATA_W-1:0]            acc_rsp_value,
  input  logic                         acc_rsp_error,
  output logic                         busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERROR   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [1:0]          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_q;
  logic [15:0]         timer;
  logic                acc_put_q;
  logic [HANDLE_W-1:0] acc_handle_q;
  logic [DATA_W-1:0]   acc_value_q;
  logic [DATA_W-1:0]   rsp_value_q;
  logic [1:0]          rsp_status_q;

  logic                any_req;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [PTR_W:0]      cand;
  logic                timer_expired;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
        cand = cand - (PTR_W + 1)'(NUM_REQ);
      end
      if (!any_req && req_valid[cand[PTR_W-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign next_ptr      = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
  assign timer_expired = (timer == TIMEOUT_C);

  // Strobes are gated by rst_n so an access is abandoned on the very first reset cycle.
  assign req_ready  = (rst_n && state == S_IDLE && any_req) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid  = (rst_n && state == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
  assign acc_valid  = rst_n && (state == S_ISSUE);
  assign busy       = rst_n && (state != S_IDLE);
  assign acc_put    = acc_put_q;
  assign acc_handle = acc_handle_q;
  assign acc_value  = acc_value_q;
  assign rsp_value  = rsp_value_q;
  assign rsp_status = rsp_status_q;

  // Sequencer: grant, issue, wait for response or expiry, report, return to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant_q      <= '0;
      timer        <= '0;
      acc_put_q    <= 1'b0;
      acc_handle_q <= '0;
      acc_value_q  <= '0;
      rsp_value_q  <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state        <= S_ISSUE;
            grant_q      <= grant_idx;
            rr_ptr       <= next_ptr;
            acc_put_q    <= req_put[grant_idx];
            acc_handle_q <= req_handle[grant_idx*HANDLE_W +: HANDLE_W];
            acc_value_q  <= req_value[grant_idx*DATA_W +: DATA_W];
            timer        <= '0;
          end
        end
        S_ISSUE: begin
          // Expiry here withdraws acc_valid; anything the channel returns later is ignored.
          if (timer_expired) begin
            state        <= S_RESP;
            rsp_status_q <= ST_TIMEOUT;
            rsp_value_q  <= '0;
          end else begin
            timer <= timer + 16'd1;
            if (acc_ready) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A response arriving on the expiry cycle still counts as a real response.
          if (acc_rsp_valid) begin
            state        <= S_RESP;
            rsp_status_q <= acc_rsp_error ? ST_ERROR : ST_OK;
            rsp_value_q  <= (acc_rsp_error || acc_put_q) ? '0 : acc_rsp_value;
          end else if (timer_expired) begin
            state        <= S_RESP;
            rsp_status_q <= ST_TIMEOUT;
            rsp_value_q  <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpi_access_arbiter.sv
// tb/tb_vpi_access_arbiter.sv - scoreboard bench for vpi_access_arbiter
module tb_vpi_access_arbiter;

  localparam int NR = 4;
  localparam int HW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  req_put;
  logic [NR*HW-1:0] req_handle;
  logic [NR*DW-1:0] req_value;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_value;
  logic [1:0]     rsp_status;
  logic           acc_valid;
  logic           acc_ready;
  logic           acc_put;
  logic [HW-1:0]  acc_handle;
  logic [DW-1:0]  acc_value;
  logic           acc_rsp_valid;
  logic [DW-1:0]  acc_rsp_value;
  logic           acc_rsp_error;
  logic           busy;

  vpi_access_arbiter #(.NUM_REQ(NR), .HANDLE_W(HW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_put(req_put),
    .req_handle(req_handle), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_status(rsp_status),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_put(acc_put),
    .acc_handle(acc_handle), .acc_value(acc_value),
    .acc_rsp_valid(acc_rsp_valid), .acc_rsp_value(acc_rsp_value),
    .acc_rsp_error(acc_rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] value;
    logic [1:0]  status;
    int          grant_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   req_left[NR];

  int   ch_ready_delay = 0;
  int   ch_rsp_delay = 1;
  bit   ch_error = 1'b0;
  bit   ch_silent = 1'b0;
  bit   ch_late = 1'b0;

  logic          last_put;
  logic [HW-1:0] last_handle;
  logic [DW-1:0] last_value;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] chan_val(input logic [15:0] h);
    return {h, ~h};
  endfunction

  task automatic raise(input int i, input logic put, input logic [HW-1:0] h, input logic [DW-1:0] v);
    @(posedge clk); #1;
    req_put[i] = put;
    req_handle[i*HW +: HW] = h;
    req_value[i*DW +: DW] = v;
    req_left[i] = 1;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cyc && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_valid == '0 && !busy) done = 1'b1;
    end
    if (!done) check_eq("wait_bound", 0, 1);
  endtask

  // Cycle counter used for latency measurement.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester agents: observe grants, log order, push expected responses, retire requests.
  initial begin
    logic [NR-1:0] rdy;
    int   idx;
    exp_t e;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      if (rdy != '0) begin
        check_eq("ready_onehot", $onehot(rdy), 1);
        idx = 0;
        for (int i = 0; i < NR; i++) if (rdy[i]) idx = i;
        check_eq("ready_on_valid", req_valid[idx], 1);
        grants.push_back(idx);
        last_put    = req_put[idx];
        last_handle = req_handle[idx*HW +: HW];
        last_value  = req_value[idx*DW +: DW];
        e.idx = idx;
        e.grant_cyc = cyc;
        if (ch_silent) begin
          e.status = 2'd2; e.value = '0; e.lat = TO + 2;
        end else begin
          e.lat = 2 + ch_ready_delay + ch_rsp_delay;
          if (ch_error) begin
            e.status = 2'd1; e.value = '0;
          end else begin
            e.status = 2'd0; e.value = last_put ? 32'd0 : chan_val(last_handle);
          end
        end
        sb.push_back(e);
        @(posedge clk); #1;
        req_left[idx]--;
        if (req_left[idx] <= 0) req_valid[idx] = 1'b0;
      end
    end
  end

  // Backdoor channel model with configurable backpressure, response delay, error and silence.
  initial begin
    acc_ready = 1'b0; acc_rsp_valid = 1'b0; acc_rsp_value = '0; acc_rsp_error = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && acc_valid) begin
        for (int k = 0; k < ch_ready_delay; k++) begin
          check_eq("bp_valid", acc_valid, 1);
          check_eq("bp_handle", acc_handle, last_handle);
          check_eq("bp_value", acc_value, last_value);
          @(negedge clk);
        end
        check_eq("acc_put", acc_put, last_put);
        check_eq("acc_handle", acc_handle, last_handle);
        check_eq("acc_value", acc_value, last_value);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        if (!ch_silent) begin
          repeat (ch_rsp_delay - 1) @(negedge clk);
          acc_rsp_valid = 1'b1;
          acc_rsp_error = ch_error;
          acc_rsp_value = chan_val(acc_handle);
          @(negedge clk);
          acc_rsp_valid = 1'b0;
          acc_rsp_error = 1'b0;
        end else if (ch_late) begin
          repeat (TO + 4) @(negedge clk);
          acc_rsp_valid = 1'b1;
          acc_rsp_value = 32'hBAD0_BAD0;
          @(negedge clk);
          acc_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Response monitor: pop the scoreboard on each rsp_valid strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_rsp", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_idx", rsp_valid, NR'(1) << e.idx);
          check_eq("rsp_value", rsp_value, e.value);
          check_eq("rsp_status", rsp_status, e.status);
          check_eq("rsp_latency", cyc - e.grant_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 open cycles", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_put = '0; req_handle = '0; req_value = '0;
    for (int i = 0; i < NR; i++) req_left[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_value", rsp_value, 0);
    check_eq("rst_rsp_status", rsp_status, 0);
    check_eq("rst_acc", {acc_valid, acc_put, acc_handle, acc_value}, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single get, minimum latency.
    raise(2, 1'b0, 16'h0042, 32'd0);
    wait_done(50);

    // Put reported as access error.
    ch_error = 1'b1;
    raise(1, 1'b1, 16'hFFFF, 32'h0000_5A5A);
    wait_done(50);
    ch_error = 1'b0;

    // Timeout with a late response that must be ignored, then a normal access.
    ch_silent = 1'b1; ch_late = 1'b1;
    raise(3, 1'b0, 16'h0777, 32'd0);
    wait_done(50);
    repeat (20) @(posedge clk);
    ch_silent = 1'b0; ch_late = 1'b0;
    raise(0, 1'b0, 16'h0100, 32'd0);
    wait_done(50);

    // Backpressure for 5 cycles, response lands on the expiry cycle.
    ch_ready_delay = 5; ch_rsp_delay = 3;
    raise(1, 1'b1, 16'hABCD, 32'h1234_5678);
    wait_done(50);
    ch_ready_delay = 0; ch_rsp_delay = 1;

    // Reset while waiting on the channel.
    ch_silent = 1'b1;
    raise(1, 1'b0, 16'h0555, 32'd0);
    repeat (4) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    check_eq("mid_rst_acc_valid", acc_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rsp", {rsp_valid, rsp_value, rsp_status}, 0);
    check_eq("mid_rst_acc_fields", {acc_put, acc_handle, acc_value}, 0);
    rst_n = 1'b1;
    ch_silent = 1'b0;
    repeat (TO + 4) @(negedge clk);
    grants.delete();

    // Fairness: all requesters held valid for two accesses each.
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      req_put[i] = 1'b0;
      req_handle[i*HW +: HW] = HW'(16'h1000 + i);
      req_left[i] = 2;
    end
    req_valid = '1;
    wait_done(200);
    check_eq("fair_count", grants.size(), 8);
    for (int k = 0; k < 8 && k < grants.size(); k++) check_eq("fair_order", grants[k], k % NR);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
